// File: rtl/mil_ctrl_pkg.sv
// Shared types and parameter defaults for the MIL bus controller.
// The retry/GAP feature is enabled by defining MIL_CTRL_RETRY_EN.
package mil_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND      = 3'd1,
    WAIT_TX   = 3'd2,
    WAIT_RESP = 3'd3,
    RECEIVE   = 3'd4,
    GAP       = 3'd5,
    DONE      = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_TIMEOUT = 2'd1,
    ST_LENGTH  = 2'd2,
    ST_ABORT   = 2'd3
  } status_t;

  localparam int RESP_TIMEOUT_DEF = 700;
  localparam int GAP_CYCLES_DEF   = 200;
  localparam int MAX_RETRY_DEF    = 2;
  localparam int TIMER_W          = 10;

endpackage

// File: rtl/mil_ctrl_timer.sv
// Clearable up-counter with terminal-count compare; holds at the limit
// so it never wraps. Shared by the response-wait and retry-gap phases.
module mil_ctrl_timer
  import mil_ctrl_pkg::*;
#(
  parameter int W = TIMER_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         tc
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != limit)) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == limit);

endmodule

// File: rtl/mil_bus_controller.sv
// MIL bus transaction controller: send a command word, await and length-check
// the response, with optional retries (define MIL_CTRL_RETRY_EN to enable).
//
//   state     | meaning
//   ----------+--------------------------------------------------
//   IDLE      | ready for a request
//   SEND      | command word offered until tx_ready
//   WAIT_TX   | waiting for transmitterBusy to rise and fall
//   WAIT_RESP | response timer running, waiting for packet_start
//   RECEIVE   | counting response words until packet_end
//   GAP       | idle spacing before a retry
//   DONE      | one-cycle completion pulse
module mil_bus_controller
  import mil_ctrl_pkg::*;
#(
  parameter int RESP_TIMEOUT = RESP_TIMEOUT_DEF,
  parameter int GAP_CYCLES   = GAP_CYCLES_DEF,
  parameter int MAX_RETRY    = MAX_RETRY_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [15:0] req_cmd,
  input  logic [5:0]  req_rcount,
  output logic        req_ready,
  input  logic        abort,
  output logic        tx_valid,
  output logic [15:0] tx_data,
  output logic        tx_is_cmd,
  input  logic        tx_ready,
  input  logic        tr_busy,
  input  logic        packet_start,
  input  logic        packet_end,
  input  logic        rx_word,
  output logic        done,
  output logic [1:0]  status,
  output logic [1:0]  retries
);

`ifdef MIL_CTRL_RETRY_EN
  localparam logic RETRY_EN = 1'b1;
`else
  localparam logic RETRY_EN = 1'b0;
`endif

  localparam logic [TIMER_W-1:0] RESP_LIMIT  = TIMER_W'(RESP_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] GAP_LIMIT   = TIMER_W'(GAP_CYCLES - 1);
  localparam logic [1:0]         RETRY_LIMIT = 2'(MAX_RETRY);

  state_t       state, state_next;
  status_t      status_q, result;
  logic [15:0]  cmd_q;
  logic [5:0]   rcount_q;
  logic [5:0]   wcnt;
  logic [1:0]   retries_q;
  logic         busy_seen;
  logic         fail;
  logic         retry_inc;
  logic         t_en;
  logic         t_tc;
  logic [TIMER_W-1:0] t_limit;
  logic [6:0]   wcnt_eff;
  logic         len_ok;

  // A word strobed together with packet_end belongs to the packet.
  assign wcnt_eff = {1'b0, wcnt} + {6'd0, rx_word};
  assign len_ok   = (wcnt_eff == ({1'b0, rcount_q} + 7'd1));

  always_comb begin
    state_next = state;
    result     = ST_OK;
    fail       = 1'b0;
    retry_inc  = 1'b0;
    t_en       = 1'b0;
    t_limit    = RESP_LIMIT;
    case (state)
      IDLE:    if (req_valid) state_next = SEND;
      SEND:    if (tx_ready) state_next = WAIT_TX;
      WAIT_TX: if (busy_seen && !tr_busy) state_next = WAIT_RESP;
      WAIT_RESP: begin
        t_en = 1'b1;
        if (packet_start) begin
          state_next = RECEIVE;
        end else if (t_tc) begin
          fail   = 1'b1;
          result = ST_TIMEOUT;
        end
      end
      RECEIVE: begin
        if (packet_end) begin
          if (len_ok) begin
            state_next = DONE;
          end else begin
            fail   = 1'b1;
            result = ST_LENGTH;
          end
        end
      end
`ifdef MIL_CTRL_RETRY_EN
      GAP: begin
        t_en    = 1'b1;
        t_limit = GAP_LIMIT;
        if (t_tc) state_next = SEND;
      end
`endif
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    if (fail) begin
      state_next = DONE;
      if (RETRY_EN && (retries_q < RETRY_LIMIT)) begin
        state_next = GAP;
        retry_inc  = 1'b1;
      end
    end

    // Abort overrides any same-cycle completion or failure.
    if (abort && (state != IDLE) && (state != DONE)) begin
      state_next = DONE;
      result     = ST_ABORT;
      retry_inc  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      status_q  <= ST_OK;
      cmd_q     <= '0;
      rcount_q  <= '0;
      wcnt      <= '0;
      retries_q <= '0;
      busy_seen <= 1'b0;
    end else begin
      state <= state_next;
      if ((state == IDLE) && req_valid) begin
        cmd_q     <= req_cmd;
        rcount_q  <= req_rcount;
        retries_q <= '0;
      end else if (retry_inc) begin
        retries_q <= retries_q + 2'd1;
      end
      if (state == SEND) begin
        busy_seen <= 1'b0;
      end else if ((state == WAIT_TX) && tr_busy) begin
        busy_seen <= 1'b1;
      end
      if (state == WAIT_RESP) begin
        wcnt <= '0;
      end else if ((state == RECEIVE) && rx_word && (wcnt != 6'h3f)) begin
        wcnt <= wcnt + 6'd1;
      end
      if ((state_next == DONE) && (state != DONE)) begin
        status_q <= result;
      end
    end
  end

  mil_ctrl_timer #(.W(TIMER_W)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (state_next != state),
    .en    (t_en),
    .limit (t_limit),
    .tc    (t_tc)
  );

  assign req_ready = (state == IDLE);
  assign tx_valid  = (state == SEND);
  assign tx_is_cmd = (state == SEND);
  assign tx_data   = cmd_q;
  assign done      = (state == DONE);
  assign status    = status_q;
`ifdef MIL_CTRL_RETRY_EN
  assign retries   = retries_q;
`else
  assign retries   = 2'b00;
`endif

endmodule
